apb_slave_mem: RTL

APB3 completer (slave) holding a word-addressed register memory. It is the responder end of the bus the APB master drives, and it is instantiated once per slave in the two-slave system. It provides programmable wait states through PREADY, reports out-of-range accesses through PSLVERR, and flags protocol violations by the requester.

---
 rtl/apb_slave_mem.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer with a word-addressed register memory.
// It adds programmable wait states, reports out-of-range accesses through
// pslverr, and pulses prot_err when the requester breaks the handshake.
//
// Bus timing. The state register names the current bus cycle. SETUP is the
// first penable cycle and DONE is the penable cycle that carries pready.
// For WAIT_CYCLES=0 the first penable cycle is also the last, so IDLE goes
// straight to DONE. For WAIT_CYCLES=1, SETUP goes straight to DONE.
// Every transfer therefore has WAIT_CYCLES+1 penable cycles.
module apb_slave_mem #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic          prot_err
);

  localparam int         IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_write, r_err;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_prdata;
  logic          r_pready, r_pslverr, r_prot_err;

  logic          w_latch, w_err_in, w_write, w_err, w_viol;
  logic [AW-1:0] w_addr;
  logic          w_pready_nx, w_pslverr_nx, w_rd_load, w_commit, w_fwd;
  logic [DW-1:0] w_rd_word;

  // A setup phase is accepted only when no transfer is in flight (or one is completing).
  assign w_latch  = (r_state == IDLE || r_state == DONE) && psel && !penable;
  // Unsigned full-width compare; the extra bit keeps DEPTH == 2**AW representable.
  assign w_err_in = ({1'b0, paddr} >= (AW+1)'(DEPTH));
  // Attributes of the transfer the next edge acts on: fresh bus values when latching, else held copies.
  assign w_addr   = w_latch ? paddr    : r_addr;
  assign w_write  = w_latch ? pwrite   : r_write;
  assign w_err    = w_latch ? w_err_in : r_err;

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state logic and requester protocol checking.
  always_comb begin
    w_state_nx = r_state;
    w_viol     = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && penable) w_viol = 1'b1;
        else if (w_latch)    w_state_nx = (WC == 4'd0) ? DONE : SETUP;
      end
      SETUP: begin
        if (!(psel && penable)) begin
          w_state_nx = IDLE;
          w_viol     = 1'b1;
        end else begin
          w_state_nx = (WC <= 4'd1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          w_state_nx = IDLE;
          w_viol     = 1'b1;
        end else if (r_cnt == 4'd2) begin
          // The counter reaches 1 on this edge.
          w_state_nx = DONE;
        end
      end
      DONE: begin
        if (w_latch) w_state_nx = (WC == 4'd0) ? DONE : SETUP;
        else         w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Output decode: pready and pslverr are registered so that they are high exactly while in DONE.
  always_comb begin
    w_pready_nx  = (w_state_nx == DONE);
    w_pslverr_nx = (w_state_nx == DONE) && w_err;
    w_rd_load    = (w_state_nx == DONE) && !w_write;
    w_commit     = (r_state == DONE) && r_write && !r_err;
    // A zero-wait read set up during a committing write must see the new data.
    w_fwd        = w_commit && (r_addr == w_addr);
    w_rd_word    = w_fwd ? r_wdata : r_mem[w_addr[IW-1:0]];
  end

  // Latch the request on its setup phase and run the wait counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_latch) begin
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_write <= pwrite;
        r_err   <= w_err_in;
      end
      if (r_state == SETUP)     r_cnt <= WC;
      else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Memory array; a write commits on the edge that leaves DONE.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_addr[IW-1:0]] <= r_wdata;
    end
  end

  // Registered response; prdata holds until the next read completes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      r_pready   <= w_pready_nx;
      r_pslverr  <= w_pslverr_nx;
      r_prot_err <= w_viol;
      if (w_rd_load) r_prdata <= w_err ? '0 : w_rd_word;
    end
  end

  assign prdata   = r_prdata;
  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  assign prot_err = r_prot_err;

endmodule
